interconn_recv_buffer: RTL and testbench
========================================

// Module: interconn_recv_buffer
// PURPOSE
//  Per-MVU receive-side staging buffer directly downstream of interconn_priority.
//  Captures every word the interconnect delivers (recv_en/addr/word/from), queues it
//  in a FIFO, and drains it into the MVU data-memory write port whenever the MVU's own
//  datapath is not using that port. No interconnect word is lost unless the FIFO overflows.
// PARAMETERS
//  N       8   number of MVUs (width of one-hot source field)
//  W       64  data word width
//  BADDR   15  memory address width
//  DEPTH   8   FIFO entries; power of 2, >=2
//  AFULL   6   almost_full asserts when count >= AFULL (1..DEPTH)
// PORTS
//  clk          in   1                  clock; all logic on rising edge
//  clr          in   1                  synchronous, active-high reset
//  recv_en      in   1                  interconnect delivers a word this cycle
//  recv_from    in   N                  one-hot source MVU of delivered word
//  recv_addr    in   BADDR              destination memory address
//  recv_word    in   W                  delivered data
//  mem_busy     in   1                  MVU owns memory port this cycle; no drain allowed
//  mem_we       out  1                  write strobe to MVU data memory
//  mem_addr     out  BADDR              write address
//  mem_wdata    out  W                  write data
//  mem_from     out  N                  source of the word being written (debug/trace)
//  count        out  $clog2(DEPTH)+1    current FIFO occupancy
//  almost_full  out  1                  count >= AFULL
//  overflow     out  1                  sticky: a word was dropped since last clr/ovf_clr
//  ovf_clr      in   1                  clears overflow and drop_cnt (same priority as clr)
//  drop_cnt     out  16                 saturating count of dropped words
// BEHAVIOUR
//  - Reset (clr=1 at edge): rd/wr pointers=0, count=0, mem_we=0, mem_addr=0, mem_wdata=0,
//    mem_from=0, overflow=0, drop_cnt=0, almost_full=0. FIFO contents discarded; clr
//    mid-drain aborts pending writes (mem_we low the cycle after clr). clr wins over all.
//  - Entry = {recv_from, recv_addr, recv_word}, stored verbatim; from is not validated.
//  - Push: at edge where recv_en=1 and (count<DEPTH or pop this cycle). wr_ptr wraps mod DEPTH.
//  - Pop: at edge where count>0 (value at start of cycle) and mem_busy=0. Popped entry is
//    registered onto mem_addr/mem_wdata/mem_from with mem_we=1 for exactly the next cycle.
//    If no pop, mem_we=0 next cycle; mem_addr/wdata/from hold last value.
//  - Latency: recv_en at cycle t -> earliest mem_we at t+2 (no bypass of empty FIFO).
//  - Throughput: 1 word/cycle sustained with mem_busy=0; order strictly FIFO.
//  - Simultaneous push+pop: count unchanged; allowed when full (pop frees slot same edge).
//  - Empty + push: push only; popped next cycle at earliest.
//  - Full + push + no pop (mem_busy=1): word dropped, overflow<=1, drop_cnt+=1 (saturates
//    at 16'hFFFF); FIFO contents untouched.
//  - ovf_clr=1: overflow<=0, drop_cnt<=0; if a drop occurs same edge, ovf_clr wins.
//  - count/almost_full update at same edge as push/pop (registered).
// TESTING
//  1. clr 10 cycles, recv_en=1 from=8'h04 addr=15'h0011 word=64'hdeadbeefdeadbeef, mem_busy=0
//     -> mem_we=1 exactly 2 cycles later with same addr/word, mem_from=8'h04, count back to 0.
//  2. 8 back-to-back words addr=1..8, mem_busy=0 -> 8 consecutive mem_we cycles, addr 1..8 in
//     order, count never exceeds 2.
//  3. mem_busy=1, push 8 words (count=8, almost_full=1 from 6th), push 9th -> overflow=1,
//     drop_cnt=1; release mem_busy -> exactly words 1..8 drained, 9th never appears.
//  4. FIFO full, mem_busy=0, recv_en=1 same cycle -> no drop, count stays 8, overflow=0.
//  5. 4 words queued, mem_busy=1, assert clr 1 cycle -> count=0, mem_we never rises afterwards.
//  6. Overflow set, pulse ovf_clr -> overflow=0, drop_cnt=0; drop+ovf_clr same edge -> both 0.

Source files
------------

// File: rtl/interconn_recv_buffer.sv
// interconn_recv_buffer: FIFO staging of interconnect words into the MVU data-memory write port
// Ports:
//   clk, clr                      clock and synchronous active-high reset
//   recv_en/from/addr/word        word delivered by the interconnect this cycle
//   mem_busy                      MVU datapath owns the memory port; no drain this cycle
//   mem_we/addr/wdata/from        registered write to MVU data memory
//   count, almost_full            registered FIFO occupancy and threshold flag
//   overflow, drop_cnt, ovf_clr   sticky drop flag, saturating drop counter, and their clear
module interconn_recv_buffer #(
    parameter int N     = 8,
    parameter int W     = 64,
    parameter int BADDR = 15,
    parameter int DEPTH = 8,
    parameter int AFULL = 6
) (
    input  logic                       clk,
    input  logic                       clr,
    input  logic                       recv_en,
    input  logic [N-1:0]               recv_from,
    input  logic [BADDR-1:0]           recv_addr,
    input  logic [W-1:0]               recv_word,
    input  logic                       mem_busy,
    output logic                       mem_we,
    output logic [BADDR-1:0]           mem_addr,
    output logic [W-1:0]               mem_wdata,
    output logic [N-1:0]               mem_from,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       almost_full,
    output logic                       overflow,
    input  logic                       ovf_clr,
    output logic [15:0]                drop_cnt
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = N + BADDR + W;

    logic [EW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          pop, push, drop;
    logic [CW-1:0] count_next;

    // A full FIFO still accepts a word when the same edge pops one out.
    always_comb begin
        pop        = (count != '0) && !mem_busy;
        push       = recv_en && ((count < CW'(DEPTH)) || pop);
        drop       = recv_en && !push;
        count_next = count + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            almost_full <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_from    <= '0;
            overflow    <= 1'b0;
            drop_cnt    <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {recv_from, recv_addr, recv_word};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                {mem_from, mem_addr, mem_wdata} <= mem[rd_ptr];
                rd_ptr                          <= rd_ptr + 1'b1;
            end
            mem_we      <= pop;
            count       <= count_next;
            almost_full <= count_next >= CW'(AFULL);
            if (ovf_clr) begin
                overflow <= 1'b0;
                drop_cnt <= '0;
            end else if (drop) begin
                overflow <= 1'b1;
                drop_cnt <= (drop_cnt == 16'hFFFF) ? drop_cnt : drop_cnt + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_interconn_recv_buffer.sv
// tb_interconn_recv_buffer: scoreboard bench for interconn_recv_buffer
module tb_interconn_recv_buffer;
    logic          clk = 1'b0;
    logic          clr, recv_en, mem_busy, ovf_clr;
    logic [7:0]    recv_from, mem_from;
    logic [14:0]   recv_addr, mem_addr;
    logic [63:0]   recv_word, mem_wdata;
    logic          mem_we, almost_full, overflow;
    logic [3:0]    count;
    logic [15:0]   drop_cnt;

    logic [86:0]   q[$];
    int            tests = 0;
    int            fails = 0;

    interconn_recv_buffer dut (
        .clk(clk), .clr(clr), .recv_en(recv_en), .recv_from(recv_from),
        .recv_addr(recv_addr), .recv_word(recv_word), .mem_busy(mem_busy),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_from(mem_from), .count(count), .almost_full(almost_full),
        .overflow(overflow), .ovf_clr(ovf_clr), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    // Monitor: every memory write must match the oldest outstanding expected entry.
    always @(negedge clk) begin
        if (mem_we) begin
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_write got addr=%h word=%h from=%h expected none",
                         mem_addr, mem_wdata, mem_from);
            end else begin
                logic [86:0] e;
                e = q.pop_front();
                if ({mem_from, mem_addr, mem_wdata} !== e) begin
                    fails++;
                    $display("FAIL write_data got %h expected %h", {mem_from, mem_addr, mem_wdata}, e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    // Present one word for one edge; expect=1 means it must later appear on the write port.
    task automatic send(input logic [7:0] f, input logic [14:0] a, input logic [63:0] w, input bit expect_out);
        recv_en = 1'b1; recv_from = f; recv_addr = a; recv_word = w;
        if (expect_out) q.push_back({f, a, w});
        step();
        recv_en = 1'b0;
    endtask

    initial begin
        clr = 1'b1; recv_en = 1'b0; mem_busy = 1'b0; ovf_clr = 1'b0;
        recv_from = '0; recv_addr = '0; recv_word = '0;
        repeat (10) step();
        clr = 1'b0;
        chk("rst_count", 64'(count), 0);
        chk("rst_we", 64'(mem_we), 0);
        chk("rst_addr", 64'(mem_addr), 0);
        chk("rst_ovf", 64'(overflow), 0);
        chk("rst_drop", 64'(drop_cnt), 0);
        chk("rst_af", 64'(almost_full), 0);

        // 1: single word, write two edges after delivery
        send(8'h04, 15'h0011, 64'hdeadbeefdeadbeef, 1);
        chk("t1_count1", 64'(count), 1);
        chk("t1_we_early", 64'(mem_we), 0);
        step();
        chk("t1_we", 64'(mem_we), 1);
        chk("t1_from", 64'(mem_from), 64'h04);
        chk("t1_addr", 64'(mem_addr), 64'h11);
        chk("t1_count0", 64'(count), 0);
        step();
        chk("t1_we_drop", 64'(mem_we), 0);

        // 2: eight back-to-back words stream through
        for (int i = 1; i <= 8; i++) begin
            send(8'(1 << (i % 8)), 15'(i), 64'h1000 + 64'(i), 1);
            chk("t2_count_le2", 64'(count <= 2), 1);
        end
        repeat (4) step();
        chk("t2_drained", 64'(q.size()), 0);

        // 3: fill while memory busy, then overflow on the ninth word
        mem_busy = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            send(8'h02, 15'h100 + 15'(i), 64'hA000 + 64'(i), 1);
            chk("t3_count", 64'(count), 64'(i));
            chk("t3_af", 64'(almost_full), 64'(i >= 6));
        end
        send(8'h02, 15'h109, 64'hA009, 0);
        chk("t3_ovf", 64'(overflow), 1);
        chk("t3_drop", 64'(drop_cnt), 1);
        chk("t3_count_full", 64'(count), 8);

        // 6a: clear overflow state
        ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
        chk("t6_ovf_clr", 64'(overflow), 0);
        chk("t6_drop_clr", 64'(drop_cnt), 0);
        chk("t6_count_kept", 64'(count), 8);

        // 4: full with concurrent pop accepts the word
        mem_busy = 1'b0;
        send(8'h80, 15'h7ABC, 64'h0123456789abcdef, 1);
        chk("t4_count", 64'(count), 8);
        chk("t4_ovf", 64'(overflow), 0);
        chk("t4_drop", 64'(drop_cnt), 0);
        repeat (12) step();
        chk("t34_drained", 64'(q.size()), 0);
        chk("t34_count0", 64'(count), 0);

        // 5: clr discards queued words; nothing is written afterwards
        mem_busy = 1'b1;
        for (int i = 0; i < 4; i++) send(8'h01, 15'h200 + 15'(i), 64'(i), 0);
        chk("t5_count4", 64'(count), 4);
        clr = 1'b1; step(); clr = 1'b0;
        chk("t5_count0", 64'(count), 0);
        chk("t5_addr0", 64'(mem_addr), 0);
        mem_busy = 1'b0;
        repeat (6) step();
        chk("t5_we", 64'(mem_we), 0);
        chk("t5_count_still0", 64'(count), 0);

        // 6b: a drop on the same edge as ovf_clr leaves both cleared
        mem_busy = 1'b1;
        for (int i = 0; i < 8; i++) send(8'h10, 15'h300 + 15'(i), 64'(i), 0);
        send(8'h10, 15'h308, 64'h8, 0);
        chk("t6_ovf_set", 64'(overflow), 1);
        ovf_clr = 1'b1;
        send(8'h10, 15'h309, 64'h9, 0);
        ovf_clr = 1'b0;
        chk("t6_same_ovf", 64'(overflow), 0);
        chk("t6_same_drop", 64'(drop_cnt), 0);
        send(8'h10, 15'h30A, 64'hA, 0);
        chk("t6_redrop_ovf", 64'(overflow), 1);
        chk("t6_redrop_cnt", 64'(drop_cnt), 1);
        clr = 1'b1; step(); clr = 1'b0; mem_busy = 1'b0;
        repeat (3) step();
        chk("end_queue_empty", 64'(q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
